// File: rtl/dso_trigger_capture.sv
// Oscilloscope trigger/capture block. It takes 16 unsigned 8-bit samples per
// clock and fires on an edge with hysteresis. A pre/post-trigger record is
// kept in a circular block RAM and read back at offsets from the record start.
module dso_trigger_capture #(
  parameter int ADDR_W = 10
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic [127:0]        data_in,
  input  logic                data_valid,
  input  logic                arm,
  input  logic [7:0]          trig_level,
  input  logic [7:0]          trig_hyst,
  input  logic                trig_slope,
  input  logic                force_trig,
  input  logic [ADDR_W-1:0]   pre_depth,
  input  logic [ADDR_W-1:0]   post_depth,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [127:0]        rd_data,
  output logic                busy,
  output logic                triggered,
  output logic                done,
  output logic [ADDR_W-1:0]   trig_word_addr,
  output logic [3:0]          trig_sample_idx
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic              hyst_q, hyst_d;
  logic              triggered_q, triggered_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [3:0]        trig_idx_q, trig_idx_d;
  logic [127:0]      rd_data_q;

  logic [ADDR_W-1:0] cnt_inc;
  logic [ADDR_W-1:0] rd_phys;
  logic              wr_en;

  logic [7:0]        lo_thr;
  logic [7:0]        hi_thr;
  logic [8:0]        hi_sum;

  logic              det_flag;
  logic [7:0]        lane_s;
  logic              fire_any;
  logic [3:0]        fire_idx;

  logic [127:0]      mem [DEPTH];

  assign cnt_inc = cnt_q + ADDR_W'(1);
  // Record start is the trigger word minus the latched pre-depth, modulo depth.
  assign rd_phys = trig_addr_q - pre_q + rd_addr;

  // Saturating hysteresis thresholds: re-arm below level-hyst (rising) or above level+hyst (falling).
  always_comb begin
    hi_sum = {1'b0, trig_level} + {1'b0, trig_hyst};
    hi_thr = hi_sum[8] ? 8'hFF : hi_sum[7:0];
    lo_thr = (trig_level >= trig_hyst) ? (trig_level - trig_hyst) : 8'd0;
  end

  // Walk the 16 lanes oldest-first, carrying the hysteresis flag lane to lane.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so each lane sees the flag left by the previous lane.
    det_flag = hyst_q;
    lane_s   = 8'd0;
    fire_any = 1'b0;
    fire_idx = 4'd0;
    for (int k = 0; k < 16; k++) begin
      lane_s = data_in[8*k +: 8];
      if (!trig_slope) begin
        if (det_flag && (lane_s >= trig_level)) begin
          if (!fire_any) fire_idx = 4'(k);
          fire_any = 1'b1;
          det_flag = 1'b0;
        end else if (lane_s < lo_thr) begin
          det_flag = 1'b1;
        end
      end else begin
        if (det_flag && (lane_s <= trig_level)) begin
          if (!fire_any) fire_idx = 4'(k);
          fire_any = 1'b1;
          det_flag = 1'b0;
        end else if (lane_s > hi_thr) begin
          det_flag = 1'b1;
        end
      end
    end
  end

  // Capture FSM: arm, pre-fill, wait for trigger, post-fill, then hold the record.
  always_comb begin
    // NOTE: every signal starts from a default so no path through the case infers a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    post_d      = post_q;
    hyst_d      = hyst_q;
    triggered_d = triggered_q;
    done_d      = done_q;
    trig_addr_d = trig_addr_q;
    trig_idx_d  = trig_idx_q;
    wr_en       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          pre_d       = pre_depth;
          post_d      = post_depth;
          wr_ptr_d    = '0;
          cnt_d       = '0;
          hyst_d      = 1'b0;
          triggered_d = 1'b0;
          done_d      = 1'b0;
          state_d     = (pre_depth == '0) ? S_WAIT : S_PRE;
        end
      end
      S_PRE: begin
        if (data_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          hyst_d   = det_flag;
          if (cnt_inc == pre_q) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_WAIT: begin
        if (data_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          hyst_d   = det_flag;
          if (fire_any || force_trig) begin
            trig_addr_d = wr_ptr_q;
            trig_idx_d  = fire_any ? fire_idx : 4'd0;
            triggered_d = 1'b1;
            cnt_d       = '0;
            if (post_q == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_POST;
            end
          end
        end
      end
      S_POST: begin
        if (data_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          hyst_d   = det_flag;
          if (cnt_inc == post_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers with synchronous active-high reset.
  always_ff @(posedge clkin) begin
    // NOTE: sequential state uses non-blocking '<=' so all flops update together on the edge.
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      hyst_q      <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      trig_addr_q <= '0;
      trig_idx_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      hyst_q      <= hyst_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      trig_addr_q <= trig_addr_d;
      trig_idx_q  <= trig_idx_d;
    end
  end

  // Sample RAM write port.
  always_ff @(posedge clkin) begin
    // NOTE: the RAM array has no reset so it maps onto block RAM; only its output register is cleared.
    if (wr_en) mem[wr_ptr_q] <= data_in;
  end

  // Registered read port addressed relative to the record start; holds when idle.
  always_ff @(posedge clkin) begin
    if (reset)      rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_phys];
  end

  assign rd_data         = rd_data_q;
  assign busy            = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign triggered       = triggered_q;
  assign done            = done_q;
  assign trig_word_addr  = trig_addr_q;
  assign trig_sample_idx = trig_idx_q;

endmodule

// File: tb/tb_dso_trigger_capture.sv
// Directed bench for dso_trigger_capture with a 16-word buffer so the
// circular wrap is reachable in a handful of words.
module tb_dso_trigger_capture;

  localparam int AW = 4;

  logic           clkin = 1'b0;
  logic           reset;
  logic [127:0]   data_in;
  logic           data_valid;
  logic           arm;
  logic [7:0]     trig_level;
  logic [7:0]     trig_hyst;
  logic           trig_slope;
  logic           force_trig;
  logic [AW-1:0]  pre_depth;
  logic [AW-1:0]  post_depth;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [127:0]   rd_data;
  logic           busy;
  logic           triggered;
  logic           done;
  logic [AW-1:0]  trig_word_addr;
  logic [3:0]     trig_sample_idx;

  int checks = 0;
  int errors = 0;

  dso_trigger_capture #(.ADDR_W(AW)) dut (
    .clkin           (clkin),
    .reset           (reset),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .arm             (arm),
    .trig_level      (trig_level),
    .trig_hyst       (trig_hyst),
    .trig_slope      (trig_slope),
    .force_trig      (force_trig),
    .pre_depth       (pre_depth),
    .post_depth      (post_depth),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .busy            (busy),
    .triggered       (triggered),
    .done            (done),
    .trig_word_addr  (trig_word_addr),
    .trig_sample_idx (trig_sample_idx)
  );

  always #5 clkin = ~clkin;

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  // One clock with the given word; inputs change and outputs are sampled 1ns after the edge.
  task automatic send(input logic [127:0] w, input logic v, input logic f);
    data_in    = w;
    data_valid = v;
    force_trig = f;
    @(posedge clkin);
    #1;
    data_valid = 1'b0;
    force_trig = 1'b0;
  endtask

  task automatic do_arm(input logic [AW-1:0] pre, input logic [AW-1:0] post);
    pre_depth  = pre;
    post_depth = post;
    arm        = 1'b1;
    @(posedge clkin);
    #1;
    arm = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [127:0] v);
    rd_en   = 1'b1;
    rd_addr = a;
    @(posedge clkin);
    #1;
    rd_en = 1'b0;
    v     = rd_data;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clkin);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered got %0b exp 0", triggered); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (rd_data !== 128'd0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    checks++; if (trig_word_addr !== 4'd0) begin errors++; $display("FAIL reset_trig_addr got %0d exp 0", trig_word_addr); end
    checks++; if (trig_sample_idx !== 4'd0) begin errors++; $display("FAIL reset_trig_idx got %0d exp 0", trig_sample_idx); end
    reset = 1'b0;
    @(posedge clkin);
    #1;
  endtask

  task automatic test_rising;
    logic [127:0] tw;
    logic [127:0] exp_w [6];
    logic [127:0] v;
    trig_level = 8'h80; trig_hyst = 8'h10; trig_slope = 1'b0;
    tw = fill(8'h90);
    for (int k = 0; k < 5; k++) tw[8*k +: 8] = 8'h60;
    exp_w[0] = fill(8'h60); exp_w[1] = fill(8'h61); exp_w[2] = tw;
    exp_w[3] = fill(8'h41); exp_w[4] = fill(8'h42); exp_w[5] = fill(8'h43);
    do_arm(4'd2, 4'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rise_busy_after_arm got %0b exp 1", busy); end
    send(exp_w[0], 1'b1, 1'b0);
    send(exp_w[1], 1'b1, 1'b0);
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL rise_pre_no_trig got %0b exp 0", triggered); end
    send(tw, 1'b1, 1'b0);
    checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL rise_triggered got %0b exp 1", triggered); end
    checks++; if (trig_sample_idx !== 4'd5) begin errors++; $display("FAIL rise_idx got %0d exp 5", trig_sample_idx); end
    checks++; if (trig_word_addr !== 4'd2) begin errors++; $display("FAIL rise_addr got %0d exp 2", trig_word_addr); end
    send(exp_w[3], 1'b1, 1'b0);
    send(exp_w[4], 1'b1, 1'b0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rise_done_early got %0b exp 0", done); end
    send(exp_w[5], 1'b1, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rise_done got %0b exp 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rise_busy_done got %0b exp 0", busy); end
    for (int i = 0; i < 6; i++) begin
      rd(4'(i), v);
      checks++; if (v !== exp_w[i]) begin errors++; $display("FAIL rise_read[%0d] got %h exp %h", i, v, exp_w[i]); end
    end
  endtask

  task automatic test_falling;
    logic [127:0] o1, o2, tw, v;
    trig_level = 8'h80; trig_hyst = 8'h10; trig_slope = 1'b1;
    for (int k = 0; k < 16; k++) begin
      o1[8*k +: 8] = (k % 2 == 0) ? 8'h85 : 8'h7C;
      o2[8*k +: 8] = (k % 2 == 0) ? 8'h90 : 8'h7C;
    end
    tw = fill(8'h7F);
    tw[7:0] = 8'h85; tw[15:8] = 8'h7C; tw[23:16] = 8'h85; tw[31:24] = 8'h95;
    do_arm(4'd0, 4'd0);
    send(o1, 1'b1, 1'b0);
    send(o2, 1'b1, 1'b0);
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL fall_osc_no_trig got %0b exp 0", triggered); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fall_busy got %0b exp 1", busy); end
    send(tw, 1'b1, 1'b0);
    checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL fall_triggered got %0b exp 1", triggered); end
    checks++; if (trig_sample_idx !== 4'd4) begin errors++; $display("FAIL fall_idx got %0d exp 4", trig_sample_idx); end
    checks++; if (trig_word_addr !== 4'd2) begin errors++; $display("FAIL fall_addr got %0d exp 2", trig_word_addr); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL fall_done got %0b exp 1", done); end
    rd(4'd0, v);
    checks++; if (v !== tw) begin errors++; $display("FAIL fall_read0 got %h exp %h", v, tw); end
  endtask

  task automatic test_force;
    logic [127:0] v;
    trig_level = 8'h80; trig_hyst = 8'h10; trig_slope = 1'b0;
    do_arm(4'd0, 4'd1);
    send(fill(8'hEE), 1'b0, 1'b1);
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL force_gap_no_trig got %0b exp 0", triggered); end
    send(fill(8'h20), 1'b1, 1'b1);
    checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL force_triggered got %0b exp 1", triggered); end
    checks++; if (trig_sample_idx !== 4'd0) begin errors++; $display("FAIL force_idx got %0d exp 0", trig_sample_idx); end
    checks++; if (trig_word_addr !== 4'd0) begin errors++; $display("FAIL force_addr got %0d exp 0", trig_word_addr); end
    send(fill(8'hDD), 1'b0, 1'b0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL force_gap_done got %0b exp 0", done); end
    send(fill(8'h21), 1'b1, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL force_done got %0b exp 1", done); end
    rd(4'd1, v);
    checks++; if (v !== fill(8'h21)) begin errors++; $display("FAIL force_read1 got %h exp %h", v, fill(8'h21)); end
  endtask

  task automatic test_arm_busy;
    logic [127:0] tw, v;
    trig_level = 8'h80; trig_hyst = 8'h10; trig_slope = 1'b0;
    tw = fill(8'h80);
    for (int k = 0; k < 3; k++) tw[8*k +: 8] = 8'h6F;
    do_arm(4'd1, 4'd2);
    send(fill(8'h6F), 1'b1, 1'b0);
    do_arm(4'd5, 4'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL armbusy_busy got %0b exp 1", busy); end
    send(tw, 1'b1, 1'b0);
    checks++; if (trig_sample_idx !== 4'd3) begin errors++; $display("FAIL armbusy_idx got %0d exp 3", trig_sample_idx); end
    checks++; if (trig_word_addr !== 4'd1) begin errors++; $display("FAIL armbusy_addr got %0d exp 1", trig_word_addr); end
    send(fill(8'h31), 1'b1, 1'b0);
    send(fill(8'h32), 1'b1, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL armbusy_done got %0b exp 1", done); end
    rd(4'd0, v);
    checks++; if (v !== fill(8'h6F)) begin errors++; $display("FAIL armbusy_read0 got %h exp %h", v, fill(8'h6F)); end
    rd(4'd3, v);
    checks++; if (v !== fill(8'h32)) begin errors++; $display("FAIL armbusy_read3 got %h exp %h", v, fill(8'h32)); end
  endtask

  task automatic test_wrap;
    logic [127:0] v;
    trig_level = 8'h80; trig_hyst = 8'h10; trig_slope = 1'b0;
    do_arm(4'd10, 4'd3);
    for (int w = 0; w < 20; w++) send(fill(8'(w)), 1'b1, 1'b0);
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL wrap_no_trig got %0b exp 0", triggered); end
    send(fill(8'd20), 1'b1, 1'b1);
    checks++; if (trig_word_addr !== 4'd4) begin errors++; $display("FAIL wrap_addr got %0d exp 4", trig_word_addr); end
    for (int w = 21; w < 24; w++) send(fill(8'(w)), 1'b1, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got %0b exp 1", done); end
    for (int i = 0; i < 14; i++) begin
      rd(4'(i), v);
      checks++; if (v !== fill(8'(10 + i))) begin errors++; $display("FAIL wrap_read[%0d] got %h exp %h", i, v, fill(8'(10 + i))); end
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] v;
    trig_level = 8'h80; trig_hyst = 8'h10; trig_slope = 1'b0;
    do_arm(4'd4, 4'd4);
    for (int i = 0; i < 4; i++) send(fill(8'(8'h20 + i)), 1'b1, 1'b0);
    send(fill(8'h50), 1'b1, 1'b1);
    send(fill(8'h51), 1'b1, 1'b0);
    rd(4'd0, v);
    checks++; if (v !== fill(8'h20)) begin errors++; $display("FAIL mid_read0 got %h exp %h", v, fill(8'h20)); end
    checks++; if (triggered !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_in_post got trig=%0b busy=%0b exp 1 1", triggered, busy); end
    reset = 1'b1;
    @(posedge clkin);
    #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %0b exp 0", done); end
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL mid_triggered got %0b exp 0", triggered); end
    checks++; if (rd_data !== 128'd0) begin errors++; $display("FAIL mid_rd_data got %h exp 0", rd_data); end
    checks++; if (trig_word_addr !== 4'd0) begin errors++; $display("FAIL mid_trig_addr got %0d exp 0", trig_word_addr); end
    do_arm(4'd0, 4'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_rearm_busy got %0b exp 1", busy); end
    send(fill(8'h77), 1'b1, 1'b1);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_rearm_done got %0b exp 1", done); end
    rd(4'd0, v);
    checks++; if (v !== fill(8'h77)) begin errors++; $display("FAIL mid_rearm_read got %h exp %h", v, fill(8'h77)); end
  endtask

  initial begin
    reset = 1'b1; data_in = '0; data_valid = 1'b0; arm = 1'b0;
    trig_level = 8'h80; trig_hyst = 8'h10; trig_slope = 1'b0; force_trig = 1'b0;
    pre_depth = '0; post_depth = '0; rd_en = 1'b0; rd_addr = '0;
    test_reset();
    test_rising();
    test_falling();
    test_force();
    test_arm_busy();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
